// File: rtl/single_unit_network_interface.sv
// rtl/single_unit_network_interface.sv - AXI-Stream to NoC local-port network interface
//
// Purpose: packetizes tlast-terminated AXI-Stream frames into HEADER/BODY/TAIL
// flits toward the router (tonet) and depacketizes received flits back into
// AXI-Stream frames (fromnet). Single clock, synchronous active-high reset.
//
// Ports:
//   clk_network_i, rst_network_i          clock and synchronous reset
//   s_axis_*                              AXI-Stream target (frames to inject)
//   m_axis_*                              AXI-Stream initiator (ejected frames)
//   network_*_o / network_ready_i         flit output toward router, per-VC ready
//   network_*_i / network_ready_o         flit input from router, per-VN ready
module single_unit_network_interface #(
    parameter int NetworkIfAddressId               = 0,
    parameter int NetworkIfFlitWidth               = 64,
    parameter int NetworkIfFlitTypeWidth           = 2,
    parameter int NetworkIfBroadcastWidth          = 1,
    parameter int NetworkIfVirtualChannelIdWidth   = 1,
    parameter int NetworkIfNumberOfVirtualChannels = 2,
    parameter int NetworkIfVirtualNetworkIdWidth   = 1,
    parameter int NetworkIfNumberOfVirtualNetworks = 2,
    parameter int AxiStreamTargetIfTDataWidth      = 64,
    parameter int AxiStreamTargetIfTIdWidth        = 4,
    parameter int AxiStreamTargetIfTDestWidth      = 8,
    parameter int AxiStreamInitiatorIfTDataWidth   = 64,
    parameter int AxiStreamInitiatorIfTIdWidth     = 4,
    parameter int AxiStreamInitiatorIfTDestWidth   = 8
) (
    input  logic                                        clk_network_i,
    input  logic                                        rst_network_i,
    input  logic                                        s_axis_tvalid_i,
    output logic                                        s_axis_tready_o,
    input  logic [AxiStreamTargetIfTDataWidth-1:0]      s_axis_tdata_i,
    input  logic                                        s_axis_tlast_i,
    input  logic [AxiStreamTargetIfTIdWidth-1:0]        s_axis_tid_i,
    input  logic [AxiStreamTargetIfTDestWidth-1:0]      s_axis_tdest_i,
    output logic                                        m_axis_tvalid_o,
    input  logic                                        m_axis_tready_i,
    output logic [AxiStreamInitiatorIfTDataWidth-1:0]   m_axis_tdata_o,
    output logic                                        m_axis_tlast_o,
    output logic [AxiStreamInitiatorIfTIdWidth-1:0]     m_axis_tid_o,
    output logic [AxiStreamInitiatorIfTDestWidth-1:0]   m_axis_tdest_o,
    output logic                                        network_valid_o,
    input  logic [NetworkIfNumberOfVirtualChannels-1:0] network_ready_i,
    output logic [NetworkIfFlitWidth-1:0]               network_flit_o,
    output logic [NetworkIfFlitTypeWidth-1:0]           network_flit_type_o,
    output logic [NetworkIfBroadcastWidth-1:0]          network_broadcast_o,
    output logic [NetworkIfVirtualChannelIdWidth-1:0]   network_virtual_channel_id_o,
    input  logic                                        network_valid_i,
    output logic [NetworkIfNumberOfVirtualNetworks-1:0] network_ready_o,
    input  logic [NetworkIfFlitWidth-1:0]               network_flit_i,
    input  logic [NetworkIfFlitTypeWidth-1:0]           network_flit_type_i,
    input  logic [NetworkIfBroadcastWidth-1:0]          network_broadcast_i,
    input  logic [NetworkIfVirtualNetworkIdWidth-1:0]   network_virtual_network_id_i
);
    localparam int FW     = NetworkIfFlitWidth;
    localparam int FTW    = NetworkIfFlitTypeWidth;
    localparam int VCW    = NetworkIfVirtualChannelIdWidth;
    localparam int VNW    = NetworkIfVirtualNetworkIdWidth;
    localparam int TDW    = AxiStreamTargetIfTDataWidth;
    localparam int TIDW   = AxiStreamTargetIfTIdWidth;
    localparam int TDESTW = AxiStreamTargetIfTDestWidth;
    localparam int IDW    = AxiStreamInitiatorIfTDataWidth;
    localparam int IIDW   = AxiStreamInitiatorIfTIdWidth;
    localparam int IDESTW = AxiStreamInitiatorIfTDestWidth;

    localparam logic [15:0]    ADDR_ID          = 16'(NetworkIfAddressId);
    localparam logic [FTW-1:0] FLIT_HEADER      = FTW'(0);
    localparam logic [FTW-1:0] FLIT_BODY        = FTW'(1);
    localparam logic [FTW-1:0] FLIT_TAIL        = FTW'(2);

    typedef enum logic [1:0] {T_IDLE, T_HDR, T_BODY, T_DRAIN} tonet_state_t;
    typedef enum logic {F_IDLE, F_LOCKED} fromnet_state_t;

    // ---------------- tonet path ----------------
    tonet_state_t      t_state_q, t_state_d;
    logic [VCW-1:0]    t_vc_q, t_vc_d;
    logic [FW-1:0]     t_flit_q, t_flit_d;
    logic [FTW-1:0]    t_type_q, t_type_d;
    logic              t_valid_q, t_valid_d;
    logic [FW-1:0]     hdr_flit;
    logic [FW-1:0]     data_flit;
    logic              vc_ready;
    logic              t_accept;

    always_comb begin
        hdr_flit = '0;
        hdr_flit[TDESTW-1:0]           = s_axis_tdest_i;
        hdr_flit[TDESTW+TIDW-1:TDESTW] = s_axis_tid_i;
        hdr_flit[FW-1:FW-16]           = ADDR_ID;
        data_flit = '0;
        data_flit[TDW-1:0] = s_axis_tdata_i;
    end

    assign vc_ready = network_ready_i[t_vc_q];

    always_comb begin
        t_state_d = t_state_q;
        t_vc_d    = t_vc_q;
        t_flit_d  = t_flit_q;
        t_type_d  = t_type_q;
        t_valid_d = t_valid_q;
        t_accept  = 1'b0;
        case (t_state_q)
            T_IDLE: begin
                // The header is built straight from the first beat's sideband;
                // the beat itself stays pending until the BODY state.
                if (s_axis_tvalid_i) begin
                    t_vc_d    = VCW'(32'(s_axis_tid_i) % NetworkIfNumberOfVirtualChannels);
                    t_flit_d  = hdr_flit;
                    t_type_d  = FLIT_HEADER;
                    t_valid_d = 1'b1;
                    t_state_d = T_HDR;
                end
            end
            T_HDR: begin
                if (vc_ready) begin
                    t_valid_d = 1'b0;
                    t_state_d = T_BODY;
                end
            end
            T_BODY: begin
                // Flit register acts as a one-entry skid: refill in the same
                // cycle it drains to sustain one flit per cycle.
                t_accept = !t_valid_q || vc_ready;
                if (t_valid_q && vc_ready) begin
                    t_valid_d = 1'b0;
                end
                if (s_axis_tvalid_i && t_accept) begin
                    t_flit_d  = data_flit;
                    t_type_d  = s_axis_tlast_i ? FLIT_TAIL : FLIT_BODY;
                    t_valid_d = 1'b1;
                    if (s_axis_tlast_i) begin
                        t_state_d = T_DRAIN;
                    end
                end
            end
            T_DRAIN: begin
                if (vc_ready) begin
                    t_valid_d = 1'b0;
                    t_state_d = T_IDLE;
                end
            end
            default: t_state_d = T_IDLE;
        endcase
    end

    always_ff @(posedge clk_network_i) begin
        if (rst_network_i) begin
            t_state_q <= T_IDLE;
            t_vc_q    <= '0;
            t_flit_q  <= '0;
            t_type_q  <= '0;
            t_valid_q <= 1'b0;
        end else begin
            t_state_q <= t_state_d;
            t_vc_q    <= t_vc_d;
            t_flit_q  <= t_flit_d;
            t_type_q  <= t_type_d;
            t_valid_q <= t_valid_d;
        end
    end

    assign s_axis_tready_o              = t_accept;
    assign network_valid_o              = t_valid_q;
    assign network_flit_o               = t_flit_q;
    assign network_flit_type_o          = t_type_q;
    assign network_virtual_channel_id_o = t_vc_q;
    assign network_broadcast_o          = '0;

    // ---------------- fromnet path ----------------
    fromnet_state_t    f_state_q, f_state_d;
    logic [VNW-1:0]    f_vn_q, f_vn_d;
    logic              m_valid_q, m_valid_d;
    logic [IDW-1:0]    m_data_q, m_data_d;
    logic              m_last_q, m_last_d;
    logic [IIDW-1:0]   m_tid_q, m_tid_d;
    logic [IDESTW-1:0] m_tdest_q, m_tdest_d;
    logic              can_take;
    logic              f_fire;

    assign can_take = !m_valid_q || m_axis_tready_i;

    // Gated by reset so the router sees no ready while the block is held in reset.
    always_comb begin
        network_ready_o = '0;
        if (!rst_network_i && can_take) begin
            if (f_state_q == F_IDLE) begin
                network_ready_o = '1;
            end else begin
                network_ready_o[f_vn_q] = 1'b1;
            end
        end
    end

    assign f_fire = network_valid_i && network_ready_o[network_virtual_network_id_i];

    always_comb begin
        f_state_d = f_state_q;
        f_vn_d    = f_vn_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_last_d  = m_last_q;
        m_tid_d   = m_tid_q;
        m_tdest_d = m_tdest_q;
        if (m_valid_q && m_axis_tready_i) begin
            m_valid_d = 1'b0;
        end
        if (f_fire) begin
            if (network_flit_type_i == FLIT_HEADER) begin
                // Also taken while LOCKED: a new header restarts the packet.
                m_tdest_d = network_flit_i[IDESTW-1:0];
                m_tid_d   = network_flit_i[IDESTW+IIDW-1:IDESTW];
                f_vn_d    = network_virtual_network_id_i;
                f_state_d = F_LOCKED;
            end else if (f_state_q == F_LOCKED &&
                         (network_flit_type_i == FLIT_BODY || network_flit_type_i == FLIT_TAIL)) begin
                m_valid_d = 1'b1;
                m_data_d  = network_flit_i[IDW-1:0];
                m_last_d  = (network_flit_type_i == FLIT_TAIL);
                if (network_flit_type_i == FLIT_TAIL) begin
                    f_state_d = F_IDLE;
                end
            end
            // Anything else (stray data while idle, HEADER_TAIL) is consumed and dropped.
        end
    end

    always_ff @(posedge clk_network_i) begin
        if (rst_network_i) begin
            f_state_q <= F_IDLE;
            f_vn_q    <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
            m_tid_q   <= '0;
            m_tdest_q <= '0;
        end else begin
            f_state_q <= f_state_d;
            f_vn_q    <= f_vn_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_last_q  <= m_last_d;
            m_tid_q   <= m_tid_d;
            m_tdest_q <= m_tdest_d;
        end
    end

    assign m_axis_tvalid_o = m_valid_q;
    assign m_axis_tdata_o  = m_data_q;
    assign m_axis_tlast_o  = m_last_q;
    assign m_axis_tid_o    = m_tid_q;
    assign m_axis_tdest_o  = m_tdest_q;

    logic unused_inputs;
    assign unused_inputs = ^{network_broadcast_i, network_flit_i};

endmodule

// File: tb/tb_single_unit_network_interface.sv
// tb/tb_single_unit_network_interface.sv - scoreboard testbench for single_unit_network_interface
module tb_single_unit_network_interface;
    logic        clk_network_i = 1'b0;
    logic        rst_network_i;
    logic        s_axis_tvalid_i;
    logic        s_axis_tready_o;
    logic [63:0] s_axis_tdata_i;
    logic        s_axis_tlast_i;
    logic [3:0]  s_axis_tid_i;
    logic [7:0]  s_axis_tdest_i;
    logic        m_axis_tvalid_o;
    logic        m_axis_tready_i;
    logic [63:0] m_axis_tdata_o;
    logic        m_axis_tlast_o;
    logic [3:0]  m_axis_tid_o;
    logic [7:0]  m_axis_tdest_o;
    logic        network_valid_o;
    logic [1:0]  network_ready_i;
    logic [63:0] network_flit_o;
    logic [1:0]  network_flit_type_o;
    logic        network_broadcast_o;
    logic        network_virtual_channel_id_o;
    logic        network_valid_i;
    logic [1:0]  network_ready_o;
    logic [63:0] network_flit_i;
    logic [1:0]  network_flit_type_i;
    logic        network_broadcast_i;
    logic        network_virtual_network_id_i;

    single_unit_network_interface dut (
        .clk_network_i                (clk_network_i),
        .rst_network_i                (rst_network_i),
        .s_axis_tvalid_i              (s_axis_tvalid_i),
        .s_axis_tready_o              (s_axis_tready_o),
        .s_axis_tdata_i               (s_axis_tdata_i),
        .s_axis_tlast_i               (s_axis_tlast_i),
        .s_axis_tid_i                 (s_axis_tid_i),
        .s_axis_tdest_i               (s_axis_tdest_i),
        .m_axis_tvalid_o              (m_axis_tvalid_o),
        .m_axis_tready_i              (m_axis_tready_i),
        .m_axis_tdata_o               (m_axis_tdata_o),
        .m_axis_tlast_o               (m_axis_tlast_o),
        .m_axis_tid_o                 (m_axis_tid_o),
        .m_axis_tdest_o               (m_axis_tdest_o),
        .network_valid_o              (network_valid_o),
        .network_ready_i              (network_ready_i),
        .network_flit_o               (network_flit_o),
        .network_flit_type_o          (network_flit_type_o),
        .network_broadcast_o          (network_broadcast_o),
        .network_virtual_channel_id_o (network_virtual_channel_id_o),
        .network_valid_i              (network_valid_i),
        .network_ready_o              (network_ready_o),
        .network_flit_i               (network_flit_i),
        .network_flit_type_i          (network_flit_type_i),
        .network_broadcast_i          (network_broadcast_i),
        .network_virtual_network_id_i (network_virtual_network_id_i)
    );

    always #5 clk_network_i = ~clk_network_i;

    localparam logic [1:0] HDR = 2'd0, BODY = 2'd1, TAIL = 2'd2, HTAIL = 2'd3;

    typedef struct {
        logic [1:0]  ty;
        logic [63:0] data;
        logic        vc;
        int          cyc;
    } flit_t;

    typedef struct {
        logic [63:0] data;
        logic        last;
        logic [3:0]  tid;
        logic [7:0]  tdest;
        int          cyc;
    } beat_t;

    typedef struct {
        logic [1:0]  ty;
        logic [63:0] data;
        logic        vn;
    } net_in_t;

    int tests = 0;
    int fails = 0;

    logic [63:0] beats[$];
    flit_t       exp_t[$];
    flit_t       obs_t[$];
    int          unstable_t;
    int          tready_stall;

    net_in_t     net_in[$];
    beat_t       exp_m[$];
    beat_t       obs_m[$];
    logic [1:0]  nrdy_log[$];
    int          unstable_m;

    // Drives one AXIS frame from beats[] for a fixed cycle budget and records
    // every flit the router side accepts. Cycle index c counts negedges; inputs
    // set at c apply to the following rising edge.
    task automatic drive_frame(input logic [3:0] tid, input logic [7:0] tdest,
                               input int stall_s, input int stall_l, input logic [1:0] stall_mask);
        int    bi;
        logic  pv;
        flit_t prev;
        flit_t cur;
        bi = 0;
        pv = 1'b0;
        unstable_t = 0;
        tready_stall = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk_network_i);
            network_ready_i = (c >= stall_s && c < stall_s + stall_l) ? stall_mask : 2'b11;
            s_axis_tid_i    = tid;
            s_axis_tdest_i  = tdest;
            if (bi < beats.size()) begin
                s_axis_tvalid_i = 1'b1;
                s_axis_tdata_i  = beats[bi];
                s_axis_tlast_i  = (bi == beats.size() - 1);
            end else begin
                s_axis_tvalid_i = 1'b0;
                s_axis_tdata_i  = '0;
                s_axis_tlast_i  = 1'b0;
            end
            #1;
            cur.ty   = network_flit_type_o;
            cur.data = network_flit_o;
            cur.vc   = network_virtual_channel_id_o;
            cur.cyc  = c;
            if (pv && (cur.ty !== prev.ty || cur.data !== prev.data || cur.vc !== prev.vc || !network_valid_o))
                unstable_t++;
            pv = 1'b0;
            if (network_valid_o) begin
                if (network_ready_i[network_virtual_channel_id_o]) begin
                    obs_t.push_back(cur);
                end else begin
                    pv = 1'b1;
                    prev = cur;
                    if (s_axis_tready_o) tready_stall++;
                end
            end
            if (s_axis_tvalid_i && s_axis_tready_o) bi++;
        end
        s_axis_tvalid_i = 1'b0;
        s_axis_tlast_i  = 1'b0;
        network_ready_i = 2'b11;
    endtask

    // Sends net_in[] toward the DUT and records every AXIS beat taken downstream.
    task automatic drive_net(input int stall_s, input int stall_l);
        int    fi;
        logic  pv;
        beat_t prev;
        beat_t cur;
        fi = 0;
        pv = 1'b0;
        unstable_m = 0;
        nrdy_log.delete();
        for (int c = 0; c < 30; c++) begin
            @(negedge clk_network_i);
            m_axis_tready_i = !(c >= stall_s && c < stall_s + stall_l);
            if (fi < net_in.size()) begin
                network_valid_i              = 1'b1;
                network_flit_type_i          = net_in[fi].ty;
                network_flit_i               = net_in[fi].data;
                network_virtual_network_id_i = net_in[fi].vn;
            end else begin
                network_valid_i              = 1'b0;
                network_flit_type_i          = '0;
                network_flit_i               = '0;
                network_virtual_network_id_i = 1'b0;
            end
            #1;
            nrdy_log.push_back(network_ready_o);
            cur.data  = m_axis_tdata_o;
            cur.last  = m_axis_tlast_o;
            cur.tid   = m_axis_tid_o;
            cur.tdest = m_axis_tdest_o;
            cur.cyc   = c;
            if (pv && (cur.data !== prev.data || cur.last !== prev.last || !m_axis_tvalid_o))
                unstable_m++;
            pv = 1'b0;
            if (m_axis_tvalid_o) begin
                if (m_axis_tready_i) obs_m.push_back(cur);
                else begin pv = 1'b1; prev = cur; end
            end
            if (network_valid_i && network_ready_o[network_virtual_network_id_i]) fi++;
        end
        network_valid_i = 1'b0;
        m_axis_tready_i = 1'b1;
    endtask

    task automatic test_reset;
        logic [147:0] data_outs;
        rst_network_i = 1'b1;
        s_axis_tvalid_i = 1'b1;
        network_valid_i = 1'b1;
        network_flit_type_i = HDR;
        repeat (2) @(posedge clk_network_i);
        @(negedge clk_network_i);
        tests++;
        if (network_valid_o !== 1'b0) begin fails++; $display("FAIL reset_net_valid: got %b want 0", network_valid_o); end
        tests++;
        if (s_axis_tready_o !== 1'b0) begin fails++; $display("FAIL reset_s_tready: got %b want 0", s_axis_tready_o); end
        tests++;
        if (m_axis_tvalid_o !== 1'b0) begin fails++; $display("FAIL reset_m_tvalid: got %b want 0", m_axis_tvalid_o); end
        tests++;
        if (network_ready_o !== 2'b00) begin fails++; $display("FAIL reset_net_ready: got %b want 00", network_ready_o); end
        data_outs = {network_flit_o, network_flit_type_o, network_virtual_channel_id_o, network_broadcast_o,
                     m_axis_tdata_o, m_axis_tlast_o, m_axis_tid_o, m_axis_tdest_o};
        tests++;
        if (data_outs !== '0) begin fails++; $display("FAIL reset_data_outs: got %h want 0", data_outs); end
        rst_network_i = 1'b0;
        s_axis_tvalid_i = 1'b0;
        network_valid_i = 1'b0;
        @(negedge clk_network_i);
        tests++;
        if (network_ready_o !== 2'b11) begin fails++; $display("FAIL idle_net_ready: got %b want 11", network_ready_o); end
    endtask

    task automatic check_tonet(input string name);
        flit_t e, o;
        tests++;
        if (obs_t.size() !== exp_t.size()) begin
            fails++; $display("FAIL %s count: got %0d flits want %0d", name, obs_t.size(), exp_t.size());
        end
        while (exp_t.size() > 0 && obs_t.size() > 0) begin
            e = exp_t.pop_front();
            o = obs_t.pop_front();
            tests++;
            if (o.ty !== e.ty || o.data !== e.data || o.vc !== e.vc || o.cyc !== e.cyc) begin
                fails++;
                $display("FAIL %s flit: got type=%0d data=%h vc=%0d cyc=%0d want type=%0d data=%h vc=%0d cyc=%0d",
                         name, o.ty, o.data, o.vc, o.cyc, e.ty, e.data, e.vc, e.cyc);
            end
        end
        exp_t.delete();
        obs_t.delete();
    endtask

    task automatic test_tonet_frame;
        beats = '{64'h11, 64'h22, 64'h33};
        exp_t.push_back('{HDR,  64'h105, 1'b1, 1});
        exp_t.push_back('{BODY, 64'h11,  1'b1, 3});
        exp_t.push_back('{BODY, 64'h22,  1'b1, 4});
        exp_t.push_back('{TAIL, 64'h33,  1'b1, 5});
        drive_frame(4'd1, 8'd5, 100, 0, 2'b11);
        check_tonet("tonet_frame");
    endtask

    task automatic test_back_pressure;
        beats = '{64'h44, 64'h55, 64'h66};
        exp_t.push_back('{HDR,  64'h309, 1'b1, 1});
        exp_t.push_back('{BODY, 64'h44,  1'b1, 3});
        exp_t.push_back('{BODY, 64'h55,  1'b1, 8});
        exp_t.push_back('{TAIL, 64'h66,  1'b1, 9});
        drive_frame(4'd3, 8'h09, 4, 4, 2'b01);
        check_tonet("back_pressure");
        tests++;
        if (unstable_t !== 0) begin fails++; $display("FAIL bp_stable: got %0d changes want 0", unstable_t); end
        tests++;
        if (tready_stall !== 0) begin fails++; $display("FAIL bp_tready: got %0d tready cycles want 0", tready_stall); end
    endtask

    task automatic test_single_beat;
        beats = '{64'hAB};
        exp_t.push_back('{HDR,  64'h007, 1'b0, 1});
        exp_t.push_back('{TAIL, 64'hAB,  1'b0, 3});
        drive_frame(4'd0, 8'h07, 100, 0, 2'b11);
        check_tonet("single_beat");
    endtask

    task automatic check_fromnet(input string name);
        beat_t e, o;
        tests++;
        if (obs_m.size() !== exp_m.size()) begin
            fails++; $display("FAIL %s count: got %0d beats want %0d", name, obs_m.size(), exp_m.size());
        end
        while (exp_m.size() > 0 && obs_m.size() > 0) begin
            e = exp_m.pop_front();
            o = obs_m.pop_front();
            tests++;
            if (o.data !== e.data || o.last !== e.last || o.tid !== e.tid || o.tdest !== e.tdest || o.cyc !== e.cyc) begin
                fails++;
                $display("FAIL %s beat: got data=%h last=%b tid=%0d tdest=%0d cyc=%0d want data=%h last=%b tid=%0d tdest=%0d cyc=%0d",
                         name, o.data, o.last, o.tid, o.tdest, o.cyc, e.data, e.last, e.tid, e.tdest, e.cyc);
            end
        end
        exp_m.delete();
        obs_m.delete();
    endtask

    task automatic test_fromnet_packet;
        net_in = '{'{HDR, 64'h203, 1'b1}, '{BODY, 64'h1, 1'b1}, '{TAIL, 64'h2, 1'b1}};
        exp_m.push_back('{64'h1, 1'b0, 4'd2, 8'd3, 2});
        exp_m.push_back('{64'h2, 1'b1, 4'd2, 8'd3, 3});
        drive_net(100, 0);
        check_fromnet("fromnet_packet");
        tests++;
        if (nrdy_log[0] !== 2'b11) begin fails++; $display("FAIL fn_ready_idle: got %b want 11", nrdy_log[0]); end
        tests++;
        if (nrdy_log[1] !== 2'b10 || nrdy_log[2] !== 2'b10) begin
            fails++; $display("FAIL fn_ready_locked: got %b %b want 10 10", nrdy_log[1], nrdy_log[2]);
        end
        tests++;
        if (nrdy_log[4] !== 2'b11) begin fails++; $display("FAIL fn_ready_after_tail: got %b want 11", nrdy_log[4]); end
    endtask

    task automatic test_fromnet_stall;
        net_in = '{'{HDR, 64'h521, 1'b0}, '{BODY, 64'hDEAD, 1'b0}, '{TAIL, 64'hBEEF, 1'b0}};
        exp_m.push_back('{64'hDEAD, 1'b0, 4'd5, 8'h21, 6});
        exp_m.push_back('{64'hBEEF, 1'b1, 4'd5, 8'h21, 7});
        drive_net(2, 4);
        check_fromnet("fromnet_stall");
        tests++;
        if (nrdy_log[1] !== 2'b01) begin fails++; $display("FAIL fs_ready_locked: got %b want 01", nrdy_log[1]); end
        tests++;
        if (nrdy_log[3] !== 2'b00) begin fails++; $display("FAIL fs_ready_stalled: got %b want 00", nrdy_log[3]); end
        tests++;
        if (unstable_m !== 0) begin fails++; $display("FAIL fs_beat_stable: got %0d changes want 0", unstable_m); end
    endtask

    task automatic test_stray;
        net_in = '{'{BODY, 64'h55, 1'b0}, '{TAIL, 64'h66, 1'b1}, '{HTAIL, 64'h777, 1'b0}};
        drive_net(100, 0);
        check_fromnet("stray_flits");
    endtask

    task automatic test_mid_reset;
        logic [147:0] data_outs;
        @(negedge clk_network_i);
        network_ready_i = 2'b00;
        s_axis_tvalid_i = 1'b1; s_axis_tdata_i = 64'h99; s_axis_tlast_i = 1'b0;
        s_axis_tid_i = 4'd1; s_axis_tdest_i = 8'd2;
        m_axis_tready_i = 1'b1;
        network_valid_i = 1'b1; network_flit_type_i = HDR;
        network_flit_i = 64'h101; network_virtual_network_id_i = 1'b0;
        @(negedge clk_network_i);
        network_valid_i = 1'b0;
        rst_network_i = 1'b1;
        @(negedge clk_network_i);
        data_outs = {network_flit_o, network_flit_type_o, network_virtual_channel_id_o, network_broadcast_o,
                     m_axis_tdata_o, m_axis_tlast_o, m_axis_tid_o, m_axis_tdest_o};
        tests++;
        if ({network_valid_o, s_axis_tready_o, m_axis_tvalid_o, network_ready_o} !== 5'b0 || data_outs !== '0) begin
            fails++;
            $display("FAIL mid_reset_outs: got valid=%b tready=%b mvalid=%b nready=%b data=%h want all 0",
                     network_valid_o, s_axis_tready_o, m_axis_tvalid_o, network_ready_o, data_outs);
        end
        rst_network_i = 1'b0;
        s_axis_tvalid_i = 1'b0;
        network_ready_i = 2'b11;
        net_in = '{'{BODY, 64'h77, 1'b0}, '{TAIL, 64'h88, 1'b0}};
        drive_net(100, 0);
        check_fromnet("after_reset_drop");
        tests++;
        if (nrdy_log[0] !== 2'b11) begin fails++; $display("FAIL after_reset_ready: got %b want 11", nrdy_log[0]); end
        tests++;
        if (network_valid_o !== 1'b0) begin fails++; $display("FAIL after_reset_tonet: got valid %b want 0", network_valid_o); end
    endtask

    initial begin
        rst_network_i = 1'b1;
        s_axis_tvalid_i = 1'b0; s_axis_tdata_i = '0; s_axis_tlast_i = 1'b0;
        s_axis_tid_i = '0; s_axis_tdest_i = '0;
        m_axis_tready_i = 1'b1;
        network_ready_i = 2'b11;
        network_valid_i = 1'b0; network_flit_i = '0; network_flit_type_i = '0;
        network_broadcast_i = 1'b0; network_virtual_network_id_i = 1'b0;
        test_reset();
        test_tonet_frame();
        test_back_pressure();
        test_fromnet_packet();
        test_fromnet_stall();
        test_stray();
        test_mid_reset();
        test_single_beat();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
